// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage constants and the queue entry type
package if_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
  localparam int IFQ_DEPTH_DEF = 2;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;
endpackage

// File: rtl/if_queue.sv
// if_queue: 2-entry instruction FIFO of {pc, inst}; flush dominates push and pop
module if_queue
  import if_stage_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  output logic [1:0]  count,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);
  ifq_entry_t [1:0] r_ent;
  logic             r_head;
  logic [1:0]       r_count;
  logic             w_tail;
  assign w_tail = r_head ^ r_count[0];
  assign count = r_count;
  assign head_pc = r_ent[r_head].pc;
  assign head_inst = r_ent[r_head].inst;
  // write at the tail, advance the head on pop, track occupancy
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_ent <= '0;
      r_head <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      if (push) r_ent[w_tail] <= '{pc: push_pc, inst: push_inst};
      r_head <= r_head ^ pop;
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: fetch PC, ROM request issue, in-flight tracking and redirect handling
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IFQ_DEPTH = IFQ_DEPTH_DEF
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_inst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
  input  logic        id_ready
);
  logic [31:0] r_fetch_pc;
  logic [31:0] r_inf_pc;
  logic        r_inf_v;
  logic [1:0]  w_count;
  logic        w_pop;
  logic [2:0]  w_occ;
  logic [31:0] w_target;
  assign w_target = br_target & ~32'd3;
  assign if_valid = (w_count != 2'd0) & ~br_taken;
  assign w_pop = if_valid & id_ready;
  assign w_occ = {1'b0, w_count} + {2'b0, r_inf_v} - {2'b0, w_pop};
  assign irom_req = ~cpu_rst & (br_taken | (w_occ < 3'(IFQ_DEPTH)));
  assign irom_addr = br_taken ? w_target : r_fetch_pc;
  assign if_pc4 = if_pc + PC_STEP;
  // a request always becomes the single in-flight slot and advances the fetch pc
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_fetch_pc <= RESET_PC;
      r_inf_pc <= 32'd0;
      r_inf_v <= 1'b0;
    end else begin
      r_inf_v <= irom_req;
      if (irom_req) begin
        r_inf_pc <= irom_addr;
        r_fetch_pc <= irom_addr + PC_STEP;
      end
    end
  end
  if_queue u_queue (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .push      (r_inf_v & ~br_taken),
    .pop       (w_pop),
    .flush     (br_taken),
    .push_pc   (r_inf_pc),
    .push_inst (irom_inst),
    .count     (w_count),
    .head_pc   (if_pc),
    .head_inst (if_inst)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch, stall, redirect, wrap and reset behaviour
module tb_if_stage;
  localparam logic [31:0] B = 32'h1C00_0000;
  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic [31:0] irom_inst = 32'd0;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        id_ready;
  int checks = 0;
  int errors = 0;
  if_stage dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .irom_req  (irom_req),
    .irom_addr (irom_addr),
    .irom_inst (irom_inst),
    .br_taken  (br_taken),
    .br_target (br_target),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_pc4    (if_pc4),
    .if_inst   (if_inst),
    .id_ready  (id_ready)
  );
  always #5 cpu_clk = ~cpu_clk;
  // synchronous ROM whose contents equal the address
  always @(posedge cpu_clk) irom_inst <= irom_addr;
  // occupancy never exceeds the queue depth
  always @(negedge cpu_clk) begin
    if (!cpu_rst) begin
      checks++;
      assert ({1'b0, dut.w_count} + {2'b0, dut.r_inf_v} <= 3'd2)
      else begin
        errors++;
        $error("FAIL occupancy: observed count=%0d inf_v=%0d expected sum<=2", dut.w_count, dut.r_inf_v);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic b, input logic [31:0] t, input logic r);
    @(negedge cpu_clk);
    br_taken = b;
    br_target = t;
    id_ready = r;
    #1;
  endtask
  initial begin
    cpu_rst = 1'b1;
    br_taken = 1'b0;
    br_target = 32'd0;
    id_ready = 1'b0;
    #2;
    chk("rst_req", irom_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_pc4", if_pc4, 4);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("first_req", irom_req, 1);
    chk("first_addr", irom_addr, B);
    cyc(0, 0, 1);
    chk("second_valid", if_valid, 0);
    chk("second_addr", irom_addr, B + 4);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1);
      chk("stream_valid", if_valid, 1);
      chk("stream_pc", if_pc, B + 4 * k);
      chk("stream_inst", if_inst, B + 4 * k);
      chk("stream_pc4", if_pc4, B + 4 * k + 4);
      chk("stream_addr", irom_addr, B + 4 * (k + 2));
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      chk("stall_valid", if_valid, 1);
      chk("stall_pc", if_pc, B + 32'h10);
      chk("stall_req", irom_req, 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      chk("release_pc", if_pc, B + 32'h10 + 4 * i);
      chk("release_req", irom_req, 1);
      chk("release_addr", irom_addr, B + 32'h18 + 4 * i);
    end
    cyc(1, B + 32'h103, 1);
    chk("br_valid", if_valid, 0);
    chk("br_req", irom_req, 1);
    chk("br_addr", irom_addr, B + 32'h100);
    cyc(0, 0, 1);
    chk("br1_valid", if_valid, 0);
    chk("br1_addr", irom_addr, B + 32'h104);
    cyc(0, 0, 1);
    chk("br2_valid", if_valid, 1);
    chk("br2_pc", if_pc, B + 32'h100);
    chk("br2_inst", if_inst, B + 32'h100);
    cyc(0, 0, 1);
    chk("br3_pc", if_pc, B + 32'h104);
    cyc(0, 0, 0);
    chk("full1_req", irom_req, 0);
    cyc(0, 0, 0);
    chk("full2_valid", if_valid, 1);
    chk("full2_pc", if_pc, B + 32'h108);
    chk("full2_count", dut.w_count, 2);
    cyc(1, B + 32'h200, 1);
    chk("bb1_valid", if_valid, 0);
    chk("bb1_addr", irom_addr, B + 32'h200);
    cyc(1, B + 32'h300, 1);
    chk("bb2_valid", if_valid, 0);
    chk("bb2_addr", irom_addr, B + 32'h300);
    cyc(0, 0, 1);
    chk("bb3_valid", if_valid, 0);
    chk("bb3_addr", irom_addr, B + 32'h304);
    cyc(0, 0, 1);
    chk("bb4_valid", if_valid, 1);
    chk("bb4_pc", if_pc, B + 32'h300);
    chk("bb4_inst", if_inst, B + 32'h300);
    cyc(0, 0, 1);
    chk("bb5_pc", if_pc, B + 32'h304);
    cyc(1, 32'hFFFF_FFFF, 1);
    chk("wrap_br_addr", irom_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 1);
    chk("wrap1_addr", irom_addr, 32'h0);
    chk("wrap1_valid", if_valid, 0);
    cyc(0, 0, 1);
    chk("wrap2_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap2_pc4", if_pc4, 32'h0);
    chk("wrap2_addr", irom_addr, 32'h4);
    cyc(0, 0, 1);
    chk("wrap3_pc", if_pc, 32'h0);
    chk("wrap3_pc4", if_pc4, 32'h4);
    cyc(0, 0, 0);
    chk("pre_rst_req", irom_req, 0);
    cyc(0, 0, 0);
    chk("pre_rst_count", dut.w_count, 2);
    chk("pre_rst_pc", if_pc, 32'h4);
    #1;
    cpu_rst = 1'b1;
    #1;
    chk("mid_rst_valid", if_valid, 0);
    chk("mid_rst_req", irom_req, 0);
    chk("mid_rst_pc", if_pc, 0);
    chk("mid_rst_count", dut.w_count, 0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    id_ready = 1'b1;
    #1;
    chk("restart_req", irom_req, 1);
    chk("restart_addr", irom_addr, B);
    cyc(0, 0, 1);
    chk("restart1_valid", if_valid, 0);
    cyc(0, 0, 1);
    chk("restart2_valid", if_valid, 1);
    chk("restart2_pc", if_pc, B);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
